// File: rtl/seqdet_pkg.sv
// Shared definitions for the serial-pattern detection subsystem.
// The optional hit counter is enabled by defining HIT_COUNT_EN.
package seqdet_pkg;

    localparam int CLK_DIV_SIM = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_ARMED = 2'd2
    } seq_state_e;

endpackage

// File: rtl/seqdet_tick_gen.sv
// Pace generator: one-cycle tick every CLK_DIV clocks; clr restarts the period.
module tick_gen #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // next count: restart on clr, wrap after the last cycle of the period
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // period counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/seqdet_stream_top.sv
// Circular serialiser plus programmable window detector, paced by tick_gen.
// Define HIT_COUNT_EN to build the saturating hit counter; otherwise hit_cnt is 0.
module seqdet_stream_top
    import seqdet_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000,
    parameter int DATA_W  = 8,
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [DATA_W-1:0]          indata,
    input  logic [PAT_W-1:0]           pattern,
    input  logic                       overlap,
    output logic                       tick,
    output logic                       dout,
    output logic [$clog2(PAT_W+1)-1:0] c_state,
    output logic                       z,
    output logic [CNT_W-1:0]           hit_cnt
);

    localparam int SW = $clog2(PAT_W + 1);
    localparam logic [SW-1:0] FULL      = SW'(PAT_W);
    localparam logic [SW-1:0] LAST_FILL = SW'(PAT_W - 1);

    logic              tick_s;
    logic              hit_s;
    logic [PAT_W-1:0]  w_nx_s;

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-1:0]  window_q, window_d;
    logic [SW-1:0]     c_state_q, c_state_d;
    logic              z_q, z_d;
    logic              loaded_q, loaded_d;
    seq_state_e        state_q, state_d;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick_s)
    );

    assign w_nx_s = {window_q[PAT_W-2:0], shreg_q[DATA_W-1]};
    assign hit_s  = (w_nx_s == pat_q) && (c_state_q >= LAST_FILL);

    // next state: reload beats tick; nothing advances until a word has been loaded
    always_comb begin
        shreg_d   = shreg_q;
        pat_d     = pat_q;
        window_d  = window_q;
        c_state_d = c_state_q;
        z_d       = z_q;
        loaded_d  = loaded_q;
        state_d   = state_q;
        if (clr) begin
            shreg_d   = indata;
            pat_d     = pattern;
            window_d  = '0;
            c_state_d = '0;
            z_d       = 1'b0;
            loaded_d  = 1'b1;
            state_d   = ST_EMPTY;
        end else if (tick_s && loaded_q) begin
            shreg_d  = {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]};
            window_d = w_nx_s;
            z_d      = hit_s;
            if (hit_s && !overlap) begin
                c_state_d = '0;
                state_d   = ST_EMPTY;
            end else if ((state_q == ST_ARMED) || (c_state_q == LAST_FILL)) begin
                c_state_d = FULL;
                state_d   = ST_ARMED;
            end else begin
                c_state_d = c_state_q + SW'(1);
                state_d   = ST_FILL;
            end
        end else begin
            z_d = z_q;
        end
    end

    // datapath and detector state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q   <= '0;
            pat_q     <= '0;
            window_q  <= '0;
            c_state_q <= '0;
            z_q       <= 1'b0;
            loaded_q  <= 1'b0;
            state_q   <= ST_EMPTY;
        end else begin
            shreg_q   <= shreg_d;
            pat_q     <= pat_d;
            window_q  <= window_d;
            c_state_q <= c_state_d;
            z_q       <= z_d;
            loaded_q  <= loaded_d;
            state_q   <= state_d;
        end
    end

`ifdef HIT_COUNT_EN
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    // saturating match counter, cleared by reload
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (clr) begin
            hit_cnt_d = '0;
        end else if (tick_s && loaded_q && hit_s && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
    end

    // hit counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
`else
    assign hit_cnt = '0;
`endif

    assign tick    = tick_s;
    assign dout    = shreg_q[DATA_W-1];
    assign c_state = c_state_q;
    assign z       = z_q;

endmodule

// File: tb/tb_seqdet_stream_top.sv
// Directed bench for seqdet_stream_top (CLK_DIV=4, DATA_W=8, PAT_W=4), both HIT_COUNT_EN builds.
module tb_seqdet_stream_top;
    import seqdet_pkg::*;

    logic       clk;
    logic       rst;
    logic       clr;
    logic [7:0] indata;
    logic [3:0] pattern;
    logic       overlap;
    logic       tick, dout, z;
    logic [2:0] c_state;
    logic [7:0] hit_cnt;
    logic       tick2, dout2, z2;
    logic [2:0] c_state2;
    logic [1:0] hit_cnt2;

    int total = 0;
    int bad   = 0;

    seqdet_stream_top #(.CLK_DIV(CLK_DIV_SIM), .DATA_W(8), .PAT_W(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .indata(indata), .pattern(pattern),
        .overlap(overlap), .tick(tick), .dout(dout), .c_state(c_state), .z(z),
        .hit_cnt(hit_cnt)
    );

    seqdet_stream_top #(.CLK_DIV(CLK_DIV_SIM), .DATA_W(8), .PAT_W(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .clr(clr), .indata(indata), .pattern(pattern),
        .overlap(overlap), .tick(tick2), .dout(dout2), .c_state(c_state2), .z(z2),
        .hit_cnt(hit_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the clock edge that consumes the next tick
    task automatic next_tick();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * CLK_DIV_SIM + 2; i++) begin
            @(negedge clk);
            if (tick) begin
                seen = 1'b1;
                break;
            end
        end
        chk("tick_timeout", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr(input logic [7:0] d, input logic [3:0] p, input logic ov);
        @(negedge clk);
        indata  = d;
        pattern = p;
        overlap = ov;
        clr     = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    // run n ticks on word B6 / pattern 1011, checking z, dout and c_state
    task automatic run_ticks(input int n, input logic ov, input logic [15:0] zexp, input string tag);
        logic [7:0] word;
        int         c_e;
        word = 8'hB6;
        c_e  = 0;
        for (int k = 1; k <= n; k++) begin
            next_tick();
            chk({tag, "_z"}, 32'(z), 32'(zexp[k-1]));
            chk({tag, "_dout"}, 32'(dout), 32'(word[7 - (k % 8)]));
            if (zexp[k-1] && !ov) c_e = 0;
            else                  c_e = (c_e + 1 > 4) ? 4 : c_e + 1;
            chk({tag, "_cstate"}, 32'(c_state), 32'(c_e));
            chk({tag, "_z_w2"}, 32'(z2), 32'(zexp[k-1]));
        end
    endtask

    initial begin
        int ticks_seen;
        int clks;
        logic [7:0] exp_cnt_ov;
        logic [7:0] exp_cnt_nov;
        logic [1:0] exp_cnt_sat;
`ifdef HIT_COUNT_EN
        exp_cnt_ov  = 8'd4;
        exp_cnt_nov = 8'd2;
        exp_cnt_sat = 2'd3;
`else
        exp_cnt_ov  = 8'd0;
        exp_cnt_nov = 8'd0;
        exp_cnt_sat = 2'd0;
`endif
        rst = 1'b0; clr = 1'b0; indata = 8'h00; pattern = 4'h0; overlap = 1'b0;

        // 1: reset state and idle pacing
        repeat (3) @(negedge clk);
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_cstate", 32'(c_state), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_hitcnt", 32'(hit_cnt), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        rst = 1'b1;
        ticks_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (tick) ticks_seen++;
            chk("idle_tick_phase", 32'(tick), 32'((i % 4) == 3));
        end
        chk("idle_tick_count", 32'(ticks_seen), 32'd5);
        chk("idle_z", 32'(z), 32'd0);
        chk("idle_cstate", 32'(c_state), 32'd0);
        chk("idle_dout", 32'(dout), 32'd0);

        // 2: overlap mode, hits after ticks 4, 7, 12, 15
        do_clr(8'hB6, 4'b1011, 1'b1);
        chk("load_dout", 32'(dout), 32'd1);
        chk("load_cstate", 32'(c_state), 32'd0);
        run_ticks(16, 1'b1, 16'h4848, "ov");
        chk("ov_hitcnt", 32'(hit_cnt), 32'(exp_cnt_ov));
        chk("ov_hitcnt_sat", 32'(hit_cnt2), 32'(exp_cnt_sat));

        // 3: non-overlap mode, hits after ticks 4 and 12
        do_clr(8'hB6, 4'b1011, 1'b0);
        chk("reload_hitcnt", 32'(hit_cnt), 32'd0);
        run_ticks(16, 1'b0, 16'h0808, "nov");
        chk("nov_hitcnt", 32'(hit_cnt), 32'(exp_cnt_nov));

        // 4: asynchronous reset mid-stream, then no output without reload
        do_clr(8'hB6, 4'b1011, 1'b1);
        run_ticks(6, 1'b1, 16'h0008, "pre_rst");
        #2;
        rst = 1'b0;
        #1;
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_cstate", 32'(c_state), 32'd0);
        chk("arst_z", 32'(z), 32'd0);
        chk("arst_hitcnt", 32'(hit_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            next_tick();
            chk("post_rst_z", 32'(z), 32'd0);
            chk("post_rst_cstate", 32'(c_state), 32'd0);
            chk("post_rst_dout", 32'(dout), 32'd0);
        end

        // 5: clr on a tick cycle reloads without shifting; next tick 4 clks later
        do_clr(8'hB6, 4'b1011, 1'b1);
        run_ticks(3, 1'b1, 16'h0000, "pre_col");
        clks = 0;
        for (int i = 0; i < 2 * CLK_DIV_SIM; i++) begin
            @(negedge clk);
            if (tick) break;
        end
        chk("col_tick_found", 32'(tick), 32'd1);
        indata = 8'h5A; pattern = 4'b0101; overlap = 1'b1; clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("col_dout", 32'(dout), 32'd0);
        chk("col_cstate", 32'(c_state), 32'd0);
        chk("col_z", 32'(z), 32'd0);
        for (int i = 1; i <= 2 * CLK_DIV_SIM; i++) begin
            @(negedge clk);
            if (tick) begin
                clks = i;
                break;
            end
        end
        chk("col_next_tick_gap", 32'(clks), 32'd4);
        @(posedge clk);
        #1;
        chk("col_dout_after", 32'(dout), 32'd1);
        chk("col_cstate_after", 32'(c_state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
